// File: rtl/risc_pkg.sv
// Shared types and defaults for the FIFO byte-to-word packer.
package risc_pkg;

    localparam int unsigned DATA_WIDTH_DEF     = 8;
    localparam int unsigned BYTES_PER_WORD_DEF = 4;
    localparam int unsigned CNT_W              = 2;
    localparam int unsigned WCNT_W             = 16;

    // Packer control states: issue a read, capture the returned byte, present the word
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        CAPT  = 2'd1,
        OUT   = 2'd2
    } pack_state_e;

endpackage

// File: rtl/fifo_word_packer.sv
// Packs bytes read from an upstream registered-read FIFO into little-endian words.
module fifo_word_packer
    import risc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned BYTES_PER_WORD = BYTES_PER_WORD_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               fifo_empty,
    input  logic [DATA_WIDTH-1:0]              fifo_data,
    output logic                               fifo_rd,
    input  logic                               flush,
    output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] word_out,
    output logic                               word_valid,
    input  logic                               word_ready,
    output logic [1:0]                         byte_cnt,
    output logic [15:0]                        word_count
);

    localparam int unsigned     WORD_W    = DATA_WIDTH * BYTES_PER_WORD;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BYTES_PER_WORD - 1);

    pack_state_e        state_q;
    logic               run_q;
    logic [WORD_W-1:0]  word_q;
    logic               valid_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WCNT_W-1:0]  wcnt_q;

    // Read strobe: only in FETCH with data available, never before the first
    // edge after reset, and a flush in the same cycle suppresses it.
    assign fifo_rd = run_q && (state_q == FETCH) && !fifo_empty && !flush;

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign byte_cnt   = cnt_q;
    assign word_count = wcnt_q;

    // Arms the read strobe once the first rising edge with reset released has passed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Packer FSM with lane register, byte counter and delivered-word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            word_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
        end else if (flush) begin
            // Flush drops any partial word, in-flight byte or pending word
            state_q <= FETCH;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (fifo_rd) begin
                        state_q <= CAPT;
                    end
                end
                CAPT: begin
                    word_q[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
                    if (cnt_q == LAST_LANE) begin
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        state_q <= OUT;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= FETCH;
                    end
                end
                OUT: begin
                    if (word_ready) begin
                        valid_q <= 1'b0;
                        wcnt_q  <= wcnt_q + WCNT_W'(1);
                        state_q <= FETCH;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer with a queue-style FIFO model and word scoreboard.
module tb_fifo_word_packer;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_data  = 8'h00;
    logic        fifo_rd;
    logic        flush      = 1'b0;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [1:0]  byte_cnt;
    logic [15:0] word_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_count = 0;

    // Upstream FIFO model: bench pushes, strobe pops with one-cycle registered data
    logic [7:0]  mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        hold_empty = 1'b1;
    int          rd_pulses = 0;
    int          rd_b2b = 0;
    logic        rd_prev = 1'b0;

    // Scoreboard of words actually handed over
    logic [31:0] dlv [0:255];
    int          dlv_n = 0;

    assign fifo_empty = hold_empty || (wr_ptr == rd_ptr);

    fifo_word_packer #(.DATA_WIDTH(8), .BYTES_PER_WORD(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .flush      (flush),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .byte_cnt   (byte_cnt),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
            rd_pulses <= rd_pulses + 1;
        end
        if (fifo_rd && rd_prev) rd_b2b <= rd_b2b + 1;
        rd_prev <= fifo_rd;
    end

    always @(posedge clk) begin
        if (rst_n && word_valid && word_ready && !flush) begin
            dlv[dlv_n] = word_out;
            dlv_n = dlv_n + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Reference: bytes in arrival order, first byte in the lowest lane
    function automatic logic [31:0] model_word(input logic [7:0] b0, input logic [7:0] b1,
                                               input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0]  b [4];
        logic [31:0] w;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        w = 32'h0;
        for (int i = 0; i < 4; i++) w = w + (32'(b[i]) << (8 * i));
        return w;
    endfunction

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (word_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", word_valid); end
        n_cmp++; if (byte_cnt !== 2'd0) begin n_bad++; $display("FAIL rst_byte_cnt: got %0d want 0", byte_cnt); end
        n_cmp++; if (word_out !== 32'h0) begin n_bad++; $display("FAIL rst_word_out: got %h want 0", word_out); end
        n_cmp++; if (word_count !== 16'd0) begin n_bad++; $display("FAIL rst_word_count: got %0d want 0", word_count); end
        n_cmp++; if (fifo_rd !== 1'b0) begin n_bad++; $display("FAIL rst_fifo_rd: got %b want 0", fifo_rd); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (fifo_rd !== 1'b0) begin n_bad++; $display("FAIL idle_fifo_rd: got %b want 0", fifo_rd); end
    endtask

    task automatic test_single_word();
        int base_rd, base_d, lat;
        bit found;
        word_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        base_rd = rd_pulses;
        base_d  = dlv_n;
        hold_empty = 1'b0;
        #1;
        n_cmp++; if (fifo_rd !== 1'b1) begin n_bad++; $display("FAIL s1_first_rd: got %b want 1", fifo_rd); end
        lat = 0; found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (word_valid === 1'b1) begin found = 1'b1; break; end
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL s1_timeout: got %b want 1", found); end
        n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL s1_latency: got %0d want 8", lat); end
        n_cmp++; if (word_out !== 32'h44332211) begin n_bad++; $display("FAIL s1_word: got %h want 44332211", word_out); end
        exp_count++;
        @(negedge clk);
        n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL s1_valid_1cyc: got %b want 0", word_valid); end
        n_cmp++; if (word_count !== 16'(exp_count)) begin n_bad++; $display("FAIL s1_count: got %0d want %0d", word_count, exp_count); end
        n_cmp++; if (rd_pulses - base_rd != 4) begin n_bad++; $display("FAIL s1_rd_pulses: got %0d want 4", rd_pulses - base_rd); end
        n_cmp++; if (dlv_n - base_d != 1) begin n_bad++; $display("FAIL s1_delivered: got %0d want 1", dlv_n - base_d); end
    endtask

    task automatic test_stall();
        bit ok, stable;
        int base_d;
        word_ready = 1'b0;
        base_d = dlv_n;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_valid(60, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL s2_timeout1: got %b want 1", ok); end
        n_cmp++; if (word_out !== model_word(8'h01, 8'h02, 8'h03, 8'h04)) begin n_bad++; $display("FAIL s2_word1: got %h want 04030201", word_out); end
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (word_valid !== 1'b1 || word_out !== 32'h04030201 || fifo_rd !== 1'b0) stable = 1'b0;
        end
        n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL s2_hold: got %b want 1", stable); end
        n_cmp++; if (word_count !== 16'(exp_count)) begin n_bad++; $display("FAIL s2_count_stall: got %0d want %0d", word_count, exp_count); end
        word_ready = 1'b1;
        @(negedge clk);
        exp_count++;
        wait_valid(60, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL s2_timeout2: got %b want 1", ok); end
        n_cmp++; if (word_out !== model_word(8'h05, 8'h06, 8'h07, 8'h08)) begin n_bad++; $display("FAIL s2_word2: got %h want 08070605", word_out); end
        @(negedge clk);
        exp_count++;
        n_cmp++; if (word_count !== 16'(exp_count)) begin n_bad++; $display("FAIL s2_count: got %0d want %0d", word_count, exp_count); end
        n_cmp++; if (dlv_n - base_d != 2 || dlv[base_d] !== 32'h04030201) begin n_bad++; $display("FAIL s2_scoreboard: got n=%0d w=%h want n=2 w=04030201", dlv_n - base_d, dlv[base_d]); end
    endtask

    task automatic test_starve();
        bit ok, held;
        word_ready = 1'b1;
        push(8'hAA); push(8'hBB);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (byte_cnt === 2'd2) begin ok = 1'b1; break; end
        end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL s3_reach2: got %b want 1", ok); end
        held = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (byte_cnt !== 2'd2 || fifo_rd !== 1'b0 || word_valid !== 1'b0) held = 1'b0;
        end
        n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL s3_retain: got %b want 1 (byte_cnt=%0d)", held, byte_cnt); end
        push(8'hCC); push(8'hDD);
        wait_valid(40, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL s3_timeout: got %b want 1", ok); end
        n_cmp++; if (word_out !== model_word(8'hAA, 8'hBB, 8'hCC, 8'hDD)) begin n_bad++; $display("FAIL s3_word: got %h want DDCCBBAA", word_out); end
        @(negedge clk);
        exp_count++;
        n_cmp++; if (word_count !== 16'(exp_count)) begin n_bad++; $display("FAIL s3_count: got %0d want %0d", word_count, exp_count); end
    endtask

    task automatic test_flush_capt();
        bit ok;
        logic [7:0] n [4];
        word_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)));
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (byte_cnt === 2'd2 && fifo_rd === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL s4_reach: got %b want 1", ok); end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        n_cmp++; if (byte_cnt !== 2'd0) begin n_bad++; $display("FAIL s4_byte_cnt: got %0d want 0", byte_cnt); end
        n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL s4_valid: got %b want 0", word_valid); end
        n_cmp++; if (word_count !== 16'(exp_count)) begin n_bad++; $display("FAIL s4_count_flush: got %0d want %0d", word_count, exp_count); end
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n[i] = 8'($urandom_range(0, 255));
            push(n[i]);
        end
        wait_valid(40, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL s4_timeout: got %b want 1", ok); end
        n_cmp++; if (word_out !== model_word(n[0], n[1], n[2], n[3])) begin n_bad++; $display("FAIL s4_word: got %h want %h", word_out, model_word(n[0], n[1], n[2], n[3])); end
        @(negedge clk);
        exp_count++;
        n_cmp++; if (word_count !== 16'(exp_count)) begin n_bad++; $display("FAIL s4_count: got %0d want %0d", word_count, exp_count); end
    endtask

    task automatic test_flush_out();
        bit ok;
        int base_d;
        logic [7:0] n [4];
        word_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
        wait_valid(40, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL s5_timeout1: got %b want 1", ok); end
        base_d = dlv_n;
        flush = 1'b1;
        word_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL s5_valid: got %b want 0", word_valid); end
        n_cmp++; if (word_count !== 16'(exp_count)) begin n_bad++; $display("FAIL s5_count: got %0d want %0d", word_count, exp_count); end
        n_cmp++; if (dlv_n != base_d) begin n_bad++; $display("FAIL s5_dropped: got %0d want %0d", dlv_n, base_d); end
        // Flush held in FETCH with data waiting must block the strobe
        n[0] = 8'($urandom_range(0, 255));
        push(n[0]);
        #1;
        n_cmp++; if (fifo_rd !== 1'b0) begin n_bad++; $display("FAIL s5_rd_suppress: got %b want 0", fifo_rd); end
        @(negedge clk);
        n_cmp++; if (byte_cnt !== 2'd0 || fifo_rd !== 1'b0) begin n_bad++; $display("FAIL s5_fetch_hold: got cnt=%0d rd=%b want 0/0", byte_cnt, fifo_rd); end
        flush = 1'b0;
        for (int i = 1; i < 4; i++) begin
            n[i] = 8'($urandom_range(0, 255));
            push(n[i]);
        end
        wait_valid(40, ok);
        n_cmp++; if (word_out !== model_word(n[0], n[1], n[2], n[3]) || ok !== 1'b1) begin n_bad++; $display("FAIL s5_word: got %h want %h", word_out, model_word(n[0], n[1], n[2], n[3])); end
        @(negedge clk);
        exp_count++;
        n_cmp++; if (word_count !== 16'(exp_count)) begin n_bad++; $display("FAIL s5_count2: got %0d want %0d", word_count, exp_count); end
    endtask

    task automatic test_reset_capt();
        bit ok;
        logic [7:0] n [4];
        word_ready = 1'b1;
        push(8'($urandom_range(0, 255)));
        push(8'($urandom_range(0, 255)));
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (byte_cnt === 2'd1 && fifo_rd === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL s6_reach: got %b want 1", ok); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (word_valid !== 1'b0 || fifo_rd !== 1'b0) begin n_bad++; $display("FAIL s6_async_ctl: got v=%b rd=%b want 0/0", word_valid, fifo_rd); end
        n_cmp++; if (byte_cnt !== 2'd0) begin n_bad++; $display("FAIL s6_async_cnt: got %0d want 0", byte_cnt); end
        n_cmp++; if (word_out !== 32'h0) begin n_bad++; $display("FAIL s6_async_word: got %h want 0", word_out); end
        n_cmp++; if (word_count !== 16'd0) begin n_bad++; $display("FAIL s6_async_count: got %0d want 0", word_count); end
        exp_count = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n[i] = 8'($urandom_range(0, 255));
            push(n[i]);
        end
        #1;
        n_cmp++; if (fifo_rd !== 1'b0) begin n_bad++; $display("FAIL s6_rd_in_reset: got %b want 0", fifo_rd); end
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_cmp++; if (fifo_rd !== 1'b0) begin n_bad++; $display("FAIL s6_rd_before_edge: got %b want 0", fifo_rd); end
        @(negedge clk);
        n_cmp++; if (fifo_rd !== 1'b1) begin n_bad++; $display("FAIL s6_rd_after_edge: got %b want 1", fifo_rd); end
        wait_valid(40, ok);
        n_cmp++; if (word_out !== model_word(n[0], n[1], n[2], n[3]) || ok !== 1'b1) begin n_bad++; $display("FAIL s6_word: got %h want %h", word_out, model_word(n[0], n[1], n[2], n[3])); end
        @(negedge clk);
        exp_count++;
        n_cmp++; if (word_count !== 16'(exp_count)) begin n_bad++; $display("FAIL s6_count: got %0d want %0d", word_count, exp_count); end
    endtask

    task automatic test_random_stream();
        localparam int NW = 12;
        logic [7:0]  bytes [NW*4];
        logic [31:0] prev_w;
        logic        prev_v, prev_r;
        logic [31:0] exp_w;
        int base_d;
        base_d = dlv_n;
        for (int i = 0; i < NW*4; i++) begin
            bytes[i] = 8'($urandom_range(0, 255));
            push(bytes[i]);
        end
        prev_v = 1'b0; prev_r = 1'b0; prev_w = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (prev_v && !prev_r && word_valid === 1'b1) begin
                n_cmp++; if (word_out !== prev_w) begin n_bad++; $display("FAIL rnd_hold: got %h want %h", word_out, prev_w); end
            end
            if (dlv_n - base_d >= NW) break;
            prev_v = word_valid;
            prev_w = word_out;
            word_ready = 1'($urandom_range(0, 1));
            prev_r = word_ready;
            hold_empty = ($urandom_range(0, 3) == 0);
        end
        hold_empty = 1'b0;
        word_ready = 1'b1;
        n_cmp++; if (dlv_n - base_d != NW) begin n_bad++; $display("FAIL rnd_done: got %0d want %0d", dlv_n - base_d, NW); end
        for (int k = 0; k < NW; k++) begin
            exp_w = model_word(bytes[4*k], bytes[4*k+1], bytes[4*k+2], bytes[4*k+3]);
            n_cmp++; if (dlv[base_d + k] !== exp_w) begin n_bad++; $display("FAIL rnd_word%0d: got %h want %h", k, dlv[base_d + k], exp_w); end
        end
        exp_count += NW;
        n_cmp++; if (word_count !== 16'(exp_count)) begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", word_count, exp_count); end
        n_cmp++; if (rd_b2b != 0) begin n_bad++; $display("FAIL rd_back_to_back: got %0d want 0", rd_b2b); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_word();
        test_stall();
        test_starve();
        test_flush_capt();
        test_flush_out();
        test_reset_capt();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one FIFO byte.
REQ-002 Parameter BYTES_PER_WORD, default 4, bytes packed per output word.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 fifo_empty  input  1  upstream FIFO holds no data.
REQ-006 fifo_data  input  DATA_WIDTH  upstream FIFO registered read data, valid the cycle after a read strobe.
REQ-007 fifo_rd  output  1  one-cycle read strobe to the upstream FIFO.
REQ-008 flush  input  1  synchronous discard of any partial or pending word.
REQ-009 word_out  output  DATA_WIDTH*BYTES_PER_WORD  assembled word, little-endian (first byte in bits [7:0]).
REQ-010 word_valid  output  1  word_out holds a complete word.
REQ-011 word_ready  input  1  consumer accepts word_out.
REQ-012 byte_cnt  output  2  bytes captured into the current partial word.
REQ-013 word_count  output  16  number of words delivered since reset.

Function
REQ-014 FSM SHALL have exactly three states: FETCH, CAPT, OUT.
REQ-015 FETCH: fifo_rd = !fifo_empty (combinational); if fifo_rd, next state is CAPT, else stay in FETCH.
REQ-016 CAPT: fifo_rd SHALL be 0; on the edge leaving CAPT, fifo_data SHALL be written into lane byte_cnt, and byte_cnt SHALL increment.
REQ-017 CAPT exit: if byte_cnt == BYTES_PER_WORD-1, go to OUT with byte_cnt reset to 0; otherwise go to FETCH.
REQ-018 At most one read SHALL be outstanding; fifo_rd SHALL never be high in two consecutive cycles.
REQ-019 Peak throughput SHALL be one byte per 2 cycles; first word_valid SHALL occur 8 cycles after the first fifo_rd when the FIFO never goes empty.
REQ-020 OUT: word_valid = 1 and word_out SHALL be held stable until word_valid && word_ready.
REQ-021 On a handshake, word_count SHALL increment by 1 (wrapping 0xFFFF to 0), and the next state SHALL be FETCH.
REQ-022 In OUT, fifo_rd SHALL be 0; no prefetch is performed.
REQ-023 word_valid SHALL be 0 in FETCH and CAPT.
REQ-024 flush SHALL have priority over all other events: next state FETCH, byte_cnt = 0, word_valid deasserted next cycle, word_count unchanged.
REQ-025 Flush in CAPT: the in-flight byte SHALL be discarded, not captured.
REQ-026 Flush in OUT together with word_ready: the word SHALL be dropped and not counted.
REQ-027 Flush in FETCH with !fifo_empty: fifo_rd SHALL be suppressed that cycle.
REQ-028 Words and fifo_empty toggling mid-word: the block SHALL wait in FETCH with no timeout, and partial bytes SHALL be retained.
REQ-029 Lanes not yet written in the current word SHALL keep their previous values; word_out is only meaningful while word_valid = 1.

Reset
REQ-030 rst_n low SHALL immediately force: state FETCH, fifo_rd 0, word_valid 0, byte_cnt 0, word_out 0, word_count 0.
REQ-031 Reset asserted in CAPT SHALL discard the in-flight byte; the upstream FIFO read is lost.
REQ-032 The first fifo_rd after reset SHALL be no earlier than the first rising edge with rst_n high.

Structure
REQ-033 The FSM state typedef (FETCH/CAPT/OUT) and the constant BYTES_PER_WORD default SHALL live in the shared package risc_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; the lane register and counters live inline.
REQ-035 All registers SHALL use the rst_n asynchronous reset; there SHALL be no latches and no combinational loops from word_ready to fifo_rd.

Verification
REQ-036 Scenario 1: FIFO preloaded with 0x11,0x22,0x33,0x44 and word_ready=1 -> word_out=0x44332211 with word_valid for 1 cycle; word_count=1; exactly 4 fifo_rd pulses.
REQ-037 Scenario 2: 8 bytes 0x01..0x08 with word_ready held low for 5 cycles -> word_out 0x04030201 stable through the stall; then 0x08070605 follows; word_count=2.
REQ-038 Scenario 3: fifo_empty=1 after 2 bytes (0xAA,0xBB) for 10 cycles, then 0xCC,0xDD -> byte_cnt=2 throughout the stall; word_out=0xDDCCBBAA.
REQ-039 Scenario 4: flush asserted in CAPT of byte 3 -> byte_cnt=0; next 4 bytes form the word; word_count is unchanged by the flush.
REQ-040 Scenario 5: flush and word_ready together in OUT -> no count increment; word_valid=0 next cycle.
REQ-041 Scenario 6: rst_n dropped asynchronously mid-CAPT -> all outputs 0 before the next edge; normal packing resumes after release.
